// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/sub, one SLICE-bit CLA slice per stage, valid/ready with back-pressure
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SLICE;
  logic advance;
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE;
    logic [WIDTH-1:LO] ao, bo;
    logic ci, vi;
    logic [SLICE:0] c;
    logic [SLICE-1:0] g, p, sm;
    logic [HI-1:0] rn, r_q;
    logic v_q, c_q;
    if (k == 0) begin : g_in
      assign ao = a;
      assign bo = b ^ {WIDTH{sub}};
      assign ci = sub | cin;
      assign vi = in_valid;
      assign rn = sm;
    end else begin : g_in
      assign ao = g_st[k-1].g_up.a_q;
      assign bo = g_st[k-1].g_up.b_q;
      assign ci = g_st[k-1].c_q;
      assign vi = g_st[k-1].v_q;
      assign rn = {sm, g_st[k-1].r_q};
    end
    assign g = ao[LO +: SLICE] & bo[LO +: SLICE];
    assign p = ao[LO +: SLICE] | bo[LO +: SLICE];
    always_comb begin
      c[0] = ci;
      for (int i = 0; i < SLICE; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end
    assign sm = ao[LO +: SLICE] ^ bo[LO +: SLICE] ^ c[SLICE-1:0];
    // data regs load only for valid beats so outputs stay 0 until the first result
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= vi;
        if (vi) begin
          c_q <= c[SLICE];
          r_q <= rn;
        end
      end
    if (k < STAGES - 1) begin : g_up
      logic [WIDTH-1:HI] a_q, b_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && vi) begin
          a_q <= ao[WIDTH-1:HI];
          b_q <= bo[WIDTH-1:HI];
        end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (advance && g_st[STAGES-1].vi) ovf <= g_st[STAGES-1].c[SLICE] ^ g_st[STAGES-1].c[SLICE-1];
  assign out_valid = g_st[STAGES-1].v_q;
  assign s = g_st[STAGES-1].r_q;
  assign cout = g_st[STAGES-1].c_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: randomized and directed checks against an integer-arithmetic reference model
module tb_pipelined_cla_adder;
  localparam int W = 16;
  localparam int SL = 4;
  localparam int ST = W / SL;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] s;
  typedef struct {
    logic [W-1:0] s;
    logic c;
    logic o;
    int t;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  bit lat_chk = 0, took = 0;

  pipelined_cla_adder #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    exp_t e;
    longint u;
    int r;
    u = sb ? longint'(x) - longint'(y) + 65536 : longint'(x) + longint'(y) + longint'(ci);
    r = sb ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.s = u[W-1:0];
    e.c = u[W];
    e.o = (r > 32767) || (r < -32768);
    e.t = 0;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid) begin
      if (q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        check("s", s, q[0].s);
        check("cout", cout, q[0].c);
        check("ovf", ovf, q[0].o);
        if (out_ready) begin
          if (lat_chk) check("latency", cyc - q[0].t, ST);
          void'(q.pop_front());
        end
      end
    end
    took = in_valid && in_ready;
    if (took) begin
      e = model(a, b, cin, sub);
      e.t = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1;
    took = 0;
    for (int i = 0; i < 50 && !took; i++) cycle();
    if (!took) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    repeat (2) cycle();
    check("idle_out_valid", out_valid, 0);
    check("idle_s", s, 0);
    lat_chk = 1;
    send(16'h7FFF, 16'h0001, 0, 0);
    drain();
    send(16'h0003, 16'h0005, 1, 1);
    send(16'h8000, 16'h0001, 0, 1);
    drain();
    for (int i = 0; i < 8; i++) send(W'(i * 16'h1111), 16'hFFFF, 1, 0);
    drain();
    lat_chk = 0;
    for (int i = 0; i < ST; i++) send(W'(16'h1234 * (i + 1)), W'(16'h0F0F + i), i[0], i[1]);
    a = 16'hABCD; b = 16'h1357; cin = 1; sub = 1; in_valid = 1;
    out_ready = 0;
    repeat (5) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      cycle();
      check("stall_not_taken", took, 0);
    end
    out_ready = 1;
    send(16'hABCD, 16'h1357, 1, 1);
    drain();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = ($urandom % 5 == 0) ? 16'h8000 : W'($urandom);
      b = ($urandom % 5 == 0) ? 16'h7FFF : W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      cycle();
    end
    drain();
    out_ready = 0;
    for (int i = 0; i < ST; i++) send(W'(16'h1111 * (i + 3)), 16'h0101, 0, 0);
    in_valid = 0;
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    #1;
    rst = 1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_s", s, 0);
    check("async_rst_cout", cout, 0);
    q.delete();
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    repeat (10) cycle();
    check("post_rst_out_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
